// File: rtl/plane_move_ctrl.sv
// Player plane position controller: one step per press, auto-repeat while held, clamped to the playfield.
// Latency: move_en_i before edge N -> position and pos_upd_o change at edge N+1; strobes are registered.
// No backpressure: freeze_i suppresses all movement and sends the FSM back to IDLE.
module plane_move_ctrl #(
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int PLANE_W       = 32,
  parameter int PLANE_H       = 32,
  parameter int INIT_X        = 304,
  parameter int INIT_Y        = 440,
  parameter int STEP          = 4,
  parameter int REPEAT_DELAY  = 2_500_000,
  parameter int REPEAT_PERIOD = 500_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_en_i,
  input  logic [1:0]     direct_i,
  input  logic           freeze_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           pos_upd_o,
  output logic           blocked_o
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Counter only ever holds DELAY-1 or PERIOD-1, so size it for the larger of the two.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LD = CNT_W'(REPEAT_PERIOD - 1);

  // Step arithmetic runs one bit wider so additions cannot wrap before clamping.
  localparam logic [X_W:0] X_MAX  = (X_W+1)'(SCREEN_W - PLANE_W);
  localparam logic [Y_W:0] Y_MAX  = (Y_W+1)'(SCREEN_H - PLANE_H);
  localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             men_q, men_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       dir_act_q, dir_act_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d;
  logic             pos_upd_q, pos_upd_d;
  logic             blocked_q, blocked_d;

  logic             do_step;
  logic [X_W:0]     x_ext, x_dec, x_inc, x_sel;
  logic [Y_W:0]     y_ext, y_dec, y_inc, y_sel;
  logic             moved;

  // Press/hold/repeat sequencing; release and freeze always win over a pending step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_act_d = dir_act_q;
    men_d     = move_en_i;
    dir_d     = direct_i;
    do_step   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (men_q && !freeze_i) begin
          do_step   = 1'b1;
          cnt_d     = DLY_LD;
          dir_act_d = dir_q;
          state_d   = S_HOLD;
        end
      end
      default: begin
        if (!men_q || freeze_i) begin
          state_d = S_IDLE;
        end else if (dir_q != dir_act_q) begin
          // A new direction restarts the initial delay, even if the counter expired now.
          do_step   = 1'b1;
          cnt_d     = DLY_LD;
          dir_act_d = dir_q;
          state_d   = S_HOLD;
        end else if (cnt_q == '0) begin
          do_step = 1'b1;
          cnt_d   = PER_LD;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // Clamped next position for the registered direction, plus the update/blocked outcome.
  always_comb begin
    x_ext = {1'b0, pos_x_q};
    y_ext = {1'b0, pos_y_q};
    x_dec = (x_ext >= STEP_X) ? (x_ext - STEP_X) : '0;
    y_dec = (y_ext >= STEP_Y) ? (y_ext - STEP_Y) : '0;
    x_inc = ((x_ext + STEP_X) > X_MAX) ? X_MAX : (x_ext + STEP_X);
    y_inc = ((y_ext + STEP_Y) > Y_MAX) ? Y_MAX : (y_ext + STEP_Y);
    x_sel = x_ext;
    y_sel = y_ext;
    case (dir_q)
      DIR_UP:    y_sel = y_dec;
      DIR_DOWN:  y_sel = y_inc;
      DIR_LEFT:  x_sel = x_dec;
      DIR_RIGHT: x_sel = x_inc;
    endcase
    moved     = (x_sel != x_ext) || (y_sel != y_ext);
    pos_x_d   = do_step ? x_sel[X_W-1:0] : pos_x_q;
    pos_y_d   = do_step ? y_sel[Y_W-1:0] : pos_y_q;
    pos_upd_d = do_step && moved;
    blocked_d = do_step && !moved;
  end

  // All state, including the input stage and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      men_q     <= 1'b0;
      dir_q     <= 2'b00;
      dir_act_q <= 2'b00;
      pos_x_q   <= X_W'(INIT_X);
      pos_y_q   <= Y_W'(INIT_Y);
      pos_upd_q <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      men_q     <= men_d;
      dir_q     <= dir_d;
      dir_act_q <= dir_act_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      pos_upd_q <= pos_upd_d;
      blocked_q <= blocked_d;
    end
  end

  assign pos_x_o   = pos_x_q;
  assign pos_y_o   = pos_y_q;
  assign pos_upd_o = pos_upd_q;
  assign blocked_o = blocked_q;

endmodule
